id_ex_stage_register: RTL and testbench

- ID/EX pipeline register for the 5-stage RISC-V core.
- Consumes the load-use hazard unit outputs: bubble_enable, forward_from_wb_stage_to_rs1 and forward_from_wb_stage_to_rs2.
- When a bubble is requested, holds the dependent instruction for one cycle and patches its operands with the write-back value.
- Also handles flush, memory-busy stall and valid tracking, and emits hold requests to IF/ID and the PC.

---
 rtl/id_ex_stage_register.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage_register.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use bubble handling, flush, stall and valid tracking.
// Optional build macro IDEX_BUBBLE_COUNT_EN adds a saturating accepted-bubble counter.
module id_ex_stage_register #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              bubble_in,
  input  logic              fwd_wb_rs1,
  input  logic              fwd_wb_rs2,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_bubble_out,
  output logic              front_hold
`ifdef IDEX_BUBBLE_COUNT_EN
  ,
  output logic [31:0]       bubble_count
`endif
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              bubbled_q, bubbled_d;
  logic              bubble_out_q, bubble_out_d;
  logic              bubble_accept;

  // Only one bubble per instruction: a second request while bubbled falls through to a load.
  assign bubble_accept = bubble_in & ~bubbled_q & ~flush & ~stall;
  assign front_hold    = stall | (bubble_in & ~bubbled_q & ~flush);

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    ctrl_d       = ctrl_q;
    bubbled_d    = bubbled_q;
    bubble_out_d = bubble_accept;
    if (flush) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      ctrl_d     = '0;
      bubbled_d  = 1'b0;
    end else if (stall || bubble_accept) begin
      // Held instruction still picks up a write-back value it depends on.
      if (fwd_wb_rs1) rs1_data_d = wb_data;
      if (fwd_wb_rs2) rs2_data_d = wb_data;
      if (bubble_accept) bubbled_d = 1'b1;
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      ctrl_d     = id_valid ? id_ctrl : '0;
      bubbled_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      ctrl_q       <= '0;
      bubbled_q    <= 1'b0;
      bubble_out_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      ctrl_q       <= ctrl_d;
      bubbled_q    <= bubbled_d;
      bubble_out_q <= bubble_out_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_ctrl       = ctrl_q;
  assign ex_bubble_out = bubble_out_q;

`ifdef IDEX_BUBBLE_COUNT_EN
  logic [31:0] count_q, count_d;

  // Saturating; flush deliberately leaves it alone.
  always_comb begin
    count_d = count_q;
    if (bubble_accept && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign bubble_count = count_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Bench for id_ex_stage_register: directed vector table followed by randomized traffic
// compared against a rule-level reference model.
module tb_id_ex_stage_register;

  logic        clk = 1'b0;
  logic        reset, flush, stall, bubble_in, fwd_wb_rs1, fwd_wb_rs2;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [15:0] id_ctrl;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_ctrl;
  logic        ex_bubble_out, front_hold;
`ifdef IDEX_BUBBLE_COUNT_EN
  logic [31:0] bubble_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage_register #(.XLEN(32), .CTRL_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall), .bubble_in(bubble_in),
    .fwd_wb_rs1(fwd_wb_rs1), .fwd_wb_rs2(fwd_wb_rs2), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_bubble_out(ex_bubble_out), .front_hold(front_hold)
`ifdef IDEX_BUBBLE_COUNT_EN
    , .bubble_count(bubble_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // f = {rst, flush, stall, bubble, fwd1, fwd2, id_valid}; x = {front_hold, ex_valid, ex_bubble_out}
  typedef struct {
    logic [6:0]  f;
    logic [31:0] wb, pc, r1, r2;
    logic [4:0]  rd;
    logic [15:0] ctrl;
    logic [2:0]  x;
    logic [31:0] epc, er1, er2;
    logic [4:0]  erd;
    logic [15:0] ectrl;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  // Reference model state: what the EX stage should hold.
  typedef struct {
    logic        valid;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] ctrl;
  } ex_t;
  ex_t   m;
  logic  m_bubbled, m_bo;
  logic [31:0] m_cnt;

  initial begin
    vecs[0]  = '{7'b1000000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 16'h0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 16'h0};
    vecs[1]  = '{7'b0000001, 32'h0, 32'h100, 32'h11, 32'h22, 5'd5, 16'h0001, 3'b010, 32'h100, 32'h11, 32'h22, 5'd5, 16'h0001};
    vecs[2]  = '{7'b0001101, 32'hDEADBEEF, 32'h104, 32'h33, 32'h44, 5'd6, 16'h0003, 3'b111, 32'h100, 32'hDEADBEEF, 32'h22, 5'd5, 16'h0001};
    vecs[3]  = '{7'b0000001, 32'h0, 32'h104, 32'h33, 32'h44, 5'd6, 16'h0003, 3'b010, 32'h104, 32'h33, 32'h44, 5'd6, 16'h0003};
    vecs[4]  = '{7'b0001001, 32'h0, 32'h108, 32'h55, 32'h66, 5'd7, 16'h0002, 3'b111, 32'h104, 32'h33, 32'h44, 5'd6, 16'h0003};
    vecs[5]  = '{7'b0001011, 32'h99, 32'h108, 32'h55, 32'h66, 5'd7, 16'h0002, 3'b010, 32'h108, 32'h55, 32'h66, 5'd7, 16'h0002};
    vecs[6]  = '{7'b0111001, 32'h0, 32'h10C, 32'h77, 32'h88, 5'd8, 16'h0001, 3'b100, 32'h0, 32'h0, 32'h0, 5'd0, 16'h0};
    vecs[7]  = '{7'b0000000, 32'h0, 32'h200, 32'h1, 32'h2, 5'd9, 16'hFFFF, 3'b000, 32'h200, 32'h1, 32'h2, 5'd9, 16'h0};
    vecs[8]  = '{7'b0000001, 32'h0, 32'h300, 32'hA, 32'hB, 5'd10, 16'h0005, 3'b010, 32'h300, 32'hA, 32'hB, 5'd10, 16'h0005};
    vecs[9]  = '{7'b0010001, 32'h0, 32'h400, 32'hC, 32'hD, 5'd11, 16'h0001, 3'b110, 32'h300, 32'hA, 32'hB, 5'd10, 16'h0005};
    vecs[10] = '{7'b0010011, 32'h42, 32'h400, 32'hC, 32'hD, 5'd11, 16'h0001, 3'b110, 32'h300, 32'hA, 32'h42, 5'd10, 16'h0005};
    vecs[11] = '{7'b0010001, 32'h0, 32'h400, 32'hC, 32'hD, 5'd11, 16'h0001, 3'b110, 32'h300, 32'hA, 32'h42, 5'd10, 16'h0005};
    vecs[12] = '{7'b0001111, 32'h77, 32'h400, 32'hC, 32'hD, 5'd11, 16'h0001, 3'b111, 32'h300, 32'h77, 32'h77, 5'd10, 16'h0005};
    vecs[13] = '{7'b1000001, 32'h0, 32'h400, 32'hC, 32'hD, 5'd11, 16'h0001, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 16'h0};
    vecs[14] = '{7'b0001001, 32'h0, 32'h500, 32'hE, 32'hF, 5'd12, 16'h0001, 3'b101, 32'h0, 32'h0, 32'h0, 5'd0, 16'h0};
    vecs[15] = '{7'b0000001, 32'h0, 32'h504, 32'h3, 32'h4, 5'd13, 16'h0001, 3'b010, 32'h504, 32'h3, 32'h4, 5'd13, 16'h0001};

    // Directed vectors from the test plan scenarios.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      {reset, flush, stall, bubble_in, fwd_wb_rs1, fwd_wb_rs2, id_valid} = vecs[i].f;
      wb_data     = vecs[i].wb;
      id_pc       = vecs[i].pc;
      id_rs1_data = vecs[i].r1;
      id_rs2_data = vecs[i].r2;
      id_imm      = vecs[i].pc + 32'd4;
      id_rd       = vecs[i].rd;
      id_rs1      = vecs[i].rd + 5'd1;
      id_rs2      = vecs[i].rd + 5'd2;
      id_ctrl     = vecs[i].ctrl;
      #1 chk($sformatf("v%0d front_hold", i), front_hold, vecs[i].x[2]);
      @(posedge clk); #1;
      chk($sformatf("v%0d ex_valid", i), ex_valid, vecs[i].x[1]);
      chk($sformatf("v%0d ex_bubble_out", i), ex_bubble_out, vecs[i].x[0]);
      chk($sformatf("v%0d ex_pc", i), ex_pc, vecs[i].epc);
      chk($sformatf("v%0d ex_rs1_data", i), ex_rs1_data, vecs[i].er1);
      chk($sformatf("v%0d ex_rs2_data", i), ex_rs2_data, vecs[i].er2);
      chk($sformatf("v%0d ex_rd", i), ex_rd, vecs[i].erd);
      chk($sformatf("v%0d ex_ctrl", i), ex_ctrl, vecs[i].ectrl);
`ifdef IDEX_BUBBLE_COUNT_EN
      if (vecs[i].f[6]) chk($sformatf("v%0d bubble_count", i), bubble_count, 32'd0);
`endif
    end

    // Randomized traffic against the reference model; first cycle forces reset.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      reset       = (c == 0) || ($urandom_range(0, 49) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      bubble_in   = ($urandom_range(0, 2) == 0);
      fwd_wb_rs1  = $urandom_range(0, 1) == 1;
      fwd_wb_rs2  = $urandom_range(0, 1) == 1;
      wb_data     = $urandom;
      id_valid    = ($urandom_range(0, 4) != 0);
      id_pc       = $urandom;
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      id_rs1      = 5'($urandom);
      id_rs2      = 5'($urandom);
      id_rd       = 5'($urandom);
      id_ctrl     = 16'($urandom);
      #1;
      if (!reset)
        chk("rnd front_hold", front_hold, stall | (bubble_in & ~m_bubbled & ~flush));

      if (reset) begin
        m = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0};
        m_bubbled = 1'b0; m_bo = 1'b0; m_cnt = 32'd0;
      end else if (flush) begin
        m = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0};
        m_bubbled = 1'b0; m_bo = 1'b0;
      end else if (stall) begin
        if (fwd_wb_rs1) m.r1d = wb_data;
        if (fwd_wb_rs2) m.r2d = wb_data;
        m_bo = 1'b0;
      end else if (bubble_in && !m_bubbled) begin
        if (fwd_wb_rs1) m.r1d = wb_data;
        if (fwd_wb_rs2) m.r2d = wb_data;
        m_bubbled = 1'b1; m_bo = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else begin
        m = '{id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
              id_valid ? id_ctrl : 16'h0};
        m_bubbled = 1'b0; m_bo = 1'b0;
      end

      @(posedge clk); #1;
      chk("rnd ex_valid", ex_valid, m.valid);
      chk("rnd ex_pc", ex_pc, m.pc);
      chk("rnd ex_rs1_data", ex_rs1_data, m.r1d);
      chk("rnd ex_rs2_data", ex_rs2_data, m.r2d);
      chk("rnd ex_imm", ex_imm, m.imm);
      chk("rnd ex_rs1", ex_rs1, m.rs1);
      chk("rnd ex_rs2", ex_rs2, m.rs2);
      chk("rnd ex_rd", ex_rd, m.rd);
      chk("rnd ex_ctrl", ex_ctrl, m.ctrl);
      chk("rnd ex_bubble_out", ex_bubble_out, m_bo);
`ifdef IDEX_BUBBLE_COUNT_EN
      chk("rnd bubble_count", bubble_count, m_cnt);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
